oam_dma: RTL and testbench

Sprite OAM DMA engine that sits directly downstream of the CPU's 16-bit address bus output (ADH:ADL), where the address bus registers leave the core. It snoops CPU writes to $4014. On a trigger it halts the CPU and takes ownership of the system bus. It then copies 256 bytes from page $XX00-$XXFF to OAMDATA ($2004) as alternating read/write cycles, and afterwards returns the bus to the CPU.

---
 rtl/oam_dma_pkg.sv | 19 +
 rtl/oam_dma_cycle_parity.sv | 19 +
 rtl/oam_dma.sv | 99 +++++++++
 tb/tb_oam_dma.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/oam_dma_pkg.sv
// Shared definitions for the sprite OAM DMA engine: FSM encoding, bus addresses
// and the read/write encoding of the system bus.
package oam_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } state_e;

    localparam logic [15:0] DEF_TRIGGER_ADDRESS = 16'h4014;
    localparam logic [15:0] DEF_OAMDATA_ADDRESS = 16'h2004;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/oam_dma_cycle_parity.sv
// Get/put cycle toggle: 0 = get (read slot), 1 = put (write slot).
// Advances once per enabled CPU cycle; shared with the DMC DMA path.
module oam_dma_cycle_parity (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_ce,
    output logic o_parity
);

    logic parity_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)   parity_q <= 1'b0;
        else if (i_ce) parity_q <= ~parity_q;
    end

    assign o_parity = parity_q;

endmodule

// File: rtl/oam_dma.sv
// Sprite OAM DMA: snoops CPU writes to the trigger address, halts the CPU and
// copies one 256-byte page to OAMDATA as alternating get/put bus cycles.
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter logic [15:0] TRIGGER_ADDRESS = DEF_TRIGGER_ADDRESS,
    parameter logic [15:0] OAMDATA_ADDRESS = DEF_OAMDATA_ADDRESS
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ce,
    input  logic [15:0] i_cpu_address,
    input  logic [7:0]  i_cpu_data,
    input  logic        i_cpu_rw,
    input  logic [7:0]  i_bus_data,
    output logic        o_halt,
    output logic        o_bus_owner,
    output logic [15:0] o_address,
    output logic [7:0]  o_data,
    output logic        o_rw
);

    state_e     state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] index_q, index_d;
    logic [7:0] latch_q, latch_d;
    logic       parity;

    oam_dma_cycle_parity u_parity (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_ce     (i_ce),
        .o_parity (parity)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            page_q  <= 8'h00;
            index_q <= 8'h00;
            latch_q <= 8'h00;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            index_q <= index_d;
            latch_q <= latch_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        page_d      = page_q;
        index_d     = index_q;
        latch_d     = latch_q;
        o_halt      = 1'b1;
        o_bus_owner = 1'b1;
        o_address   = OAMDATA_ADDRESS;
        o_rw        = RW_READ;
        o_data      = latch_q;

        unique case (state_q)
            ST_IDLE: begin
                o_halt      = 1'b0;
                o_bus_owner = 1'b0;
                o_address   = 16'h0000;
                if (i_ce && i_cpu_rw == RW_WRITE && i_cpu_address == TRIGGER_ADDRESS) begin
                    page_d  = i_cpu_data;
                    index_d = 8'h00;
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                // CPU still owns the bus this cycle; reads must land on get cycles
                o_bus_owner = 1'b0;
                o_address   = 16'h0000;
                if (i_ce) state_d = parity ? ST_READ : ST_ALIGN;
            end
            ST_ALIGN: begin
                if (i_ce) state_d = ST_READ;
            end
            ST_READ: begin
                o_address = {page_q, index_q};
                if (i_ce) begin
                    latch_d = i_bus_data;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                o_rw = RW_WRITE;
                if (i_ce) begin
                    index_d = index_q + 8'd1;
                    state_d = (index_q == 8'hFF) ? ST_IDLE : ST_READ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: a cycle-level expectation queue built from the transfer
// rules, a table of directed transfers, a reset-abort sequence and random runs.
module tb_oam_dma;
    import oam_dma_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, ce = 1'b0, cpu_rw = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_data = 8'h00, key = 8'hA5;
    logic [7:0]  bus_data;
    logic        halt, owner, rw;
    logic [15:0] addr;
    logic [7:0]  data;

    always #5 clk = ~clk;

    // memory model: every byte is its low address byte xor a per-test key
    assign bus_data = addr[7:0] ^ key;

    oam_dma dut (
        .i_clk(clk), .i_reset(rst), .i_ce(ce),
        .i_cpu_address(cpu_addr), .i_cpu_data(cpu_data), .i_cpu_rw(cpu_rw),
        .i_bus_data(bus_data),
        .o_halt(halt), .o_bus_owner(owner), .o_address(addr), .o_data(data), .o_rw(rw)
    );

    typedef struct {
        logic        halt, owner, rw, addr_care;
        logic [15:0] addr;
        logic        data_care;
        logic [7:0]  data;
    } obs_t;

    typedef struct {
        logic [7:0]  page;
        int          par;
        int          duty;
        logic [7:0]  key;
        int          halt;
        logic [15:0] first;
        logic [7:0]  last;
    } row_t;

    obs_t        exp_q[$];
    int          total = 0, bad = 0;
    int          en_cnt = 0;
    logic [7:0]  last_latch = 8'h00;
    int          halt_cnt = 0, wr_cnt = 0;
    logic [15:0] first_rd = 16'h0000;
    logic        first_seen = 1'b0;
    logic [7:0]  last_wr = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected enabled-cycle sequence after a trigger on enabled cycle t:
    // one halt cycle, then reads only on even cycles since reset.
    task automatic build(input logic [7:0] pg, input int t);
        int         fr;
        logic [7:0] prev;
        logic [15:0] a;
        fr = t + 2;
        if (fr % 2 != 0) fr++;
        exp_q.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 8'h00});
        repeat (fr - (t + 2)) exp_q.push_back('{1'b1, 1'b1, 1'b1, 1'b1, DEF_OAMDATA_ADDRESS, 1'b1, last_latch});
        prev = last_latch;
        for (int i = 0; i < 256; i++) begin
            a = {pg, 8'(i)};
            exp_q.push_back('{1'b1, 1'b1, 1'b1, 1'b1, a, 1'b1, prev});
            prev = a[7:0] ^ key;
            exp_q.push_back('{1'b1, 1'b1, 1'b0, 1'b1, DEF_OAMDATA_ADDRESS, 1'b1, prev});
        end
        last_latch = prev;
    endtask

    always @(negedge clk) begin
        obs_t e;
        bit   was_idle;
        if (rst) begin
            exp_q.delete();
            en_cnt = 0; last_latch = 8'h00;
            halt_cnt = 0; wr_cnt = 0; first_seen = 1'b0;
        end else if (ce) begin
            was_idle = (exp_q.size() == 0);
            if (was_idle) e = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, last_latch};
            else          e = exp_q.pop_front();
            chk("halt", 32'(halt), 32'(e.halt));
            chk("owner", 32'(owner), 32'(e.owner));
            if (e.owner || was_idle) chk("rw", 32'(rw), 32'(e.rw));
            if (e.addr_care) chk("addr", 32'(addr), 32'(e.addr));
            if (e.data_care) chk("data", 32'(data), 32'(e.data));
            if (halt) halt_cnt++;
            if (owner && !rw && addr == DEF_OAMDATA_ADDRESS) begin
                wr_cnt++; last_wr = data;
            end
            if (owner && rw && addr != DEF_OAMDATA_ADDRESS && !first_seen) begin
                first_seen = 1'b1; first_rd = addr;
            end
            if (was_idle && !cpu_rw && cpu_addr == DEF_TRIGGER_ADDRESS) begin
                halt_cnt = 0; wr_cnt = 0; first_seen = 1'b0;
                build(cpu_data, en_cnt);
            end
            en_cnt++;
        end
    end

    task automatic drive(input logic c, input logic [15:0] a, input logic [7:0] d, input logic w);
        ce = c; cpu_addr = a; cpu_data = d; cpu_rw = w;
        @(posedge clk);
        #1;
    endtask

    function automatic logic duty_ce(input int mode, input int n);
        case (mode)
            0:       return 1'b1;
            1:       return (n % 4 == 0);
            default: return ($urandom_range(0, 3) == 0);
        endcase
    endfunction

    // Start a transfer from IDLE and run it to completion; returns done flag.
    task automatic transfer(input logic [7:0] pg, input int par, input int duty, output bit done);
        int n;
        while ((en_cnt % 2) != par) drive(1'b1, 16'h0000, 8'h00, 1'b1);
        drive(1'b1, DEF_TRIGGER_ADDRESS, pg, 1'b0);
        done = 0;
        n = 0;
        while (n < 6000 && !done) begin
            drive(duty_ce(duty, n), 16'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            n++;
            if (exp_q.size() == 0 && !halt) done = 1;
        end
    endtask

    task automatic run_row(input row_t r, input string tag);
        bit done;
        key = r.key;
        transfer(r.page, r.par, r.duty, done);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_halt_len"}, 32'(halt_cnt), 32'(r.halt));
        chk({tag, "_writes"}, 32'(wr_cnt), 32'd256);
        chk({tag, "_first_rd"}, 32'(first_rd), 32'(r.first));
        chk({tag, "_last_wr"}, 32'(last_wr), 32'(r.last));
    endtask

    row_t rows[6];

    initial begin
        bit done;
        rows[0] = '{8'h02, 0, 0, 8'hA5, 513, 16'h0200, 8'h5A};
        rows[1] = '{8'h02, 1, 0, 8'hA5, 514, 16'h0200, 8'h5A};
        rows[2] = '{8'h40, 0, 1, 8'h3C, 513, 16'h4000, 8'hC3};
        rows[3] = '{8'hC7, 1, 1, 8'h00, 514, 16'hC700, 8'hFF};
        rows[4] = '{8'hFF, 0, 2, 8'h81, 513, 16'hFF00, 8'h7E};
        rows[5] = '{8'h07, 1, 0, 8'h5A, 514, 16'h0700, 8'hA5};

        #2;
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_addr", 32'(addr), 32'h0000);
        chk("rst_data", 32'(data), 32'h00);
        chk("rst_rw", 32'(rw), 32'd1);
        drive(1'b0, 16'h0000, 8'h00, 1'b1);
        drive(1'b0, 16'h0000, 8'h00, 1'b1);
        rst = 1'b0;
        repeat (10) drive(1'b1, 16'h0000, 8'h00, 1'b1);
        chk("idle_addr", 32'(addr), 32'h0000);
        chk("idle_halt", 32'(halt), 32'd0);

        for (int i = 0; i < 5; i++) run_row(rows[i], $sformatf("row%0d", i));

        // reset during a transfer
        key = 8'h11;
        drive(1'b1, DEF_TRIGGER_ADDRESS, 8'h03, 1'b0);
        repeat (100) drive(1'b1, 16'h0000, 8'h00, 1'b1);
        chk("mid_halt", 32'(halt), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("abort_halt", 32'(halt), 32'd0);
        chk("abort_owner", 32'(owner), 32'd0);
        chk("abort_rw", 32'(rw), 32'd1);
        chk("abort_data", 32'(data), 32'h00);
        @(posedge clk); #1;
        drive(1'b1, 16'h0000, 8'h00, 1'b1);
        rst = 1'b0;
        repeat (20) drive(1'b1, 16'h0000, 8'h00, 1'b1);
        chk("abort_no_writes", 32'(wr_cnt), 32'd0);
        chk("abort_no_halt", 32'(halt_cnt), 32'd0);
        run_row(rows[5], "restart");

        // random transfers with random CPU traffic between them
        for (int k = 0; k < 6; k++) begin
            logic [15:0] a;
            repeat ($urandom_range(0, 7)) begin
                a = 16'($urandom);
                if (a == DEF_TRIGGER_ADDRESS) a = 16'h4015;
                drive(1'($urandom_range(0, 1)), a, 8'($urandom), 1'($urandom_range(0, 1)));
            end
            key = 8'($urandom);
            transfer(8'($urandom), $urandom_range(0, 1), $urandom_range(0, 2), done);
            chk("rand_done", 32'(done), 32'd1);
            chk("rand_writes", 32'(wr_cnt), 32'd256);
        end
        repeat (4) drive(1'b1, 16'h0000, 8'h00, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
